// File: rtl/ahb_timer_satellite.sv
// AHB-Lite timer satellite: 32-bit up-counter with prescaler, compare match and a
// registered level interrupt. Zero-wait legal accesses, two-cycle ERROR response otherwise.
module ahb_timer_satellite #(
  parameter int unsigned PRESCALE_W    = 16,
  parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata,
  output logic        timer_irq
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_PRE    = 3'd1;
  localparam logic [2:0] OFF_COUNT  = 3'd2;
  localparam logic [2:0] OFF_CMP    = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;
  localparam logic [PRESCALE_W-1:0] PCNT_ONE = PRESCALE_W'(1);

  state_t                r_state;
  logic                  r_hreadyout;
  logic                  r_hresp;
  logic [2:0]            r_off;
  logic                  r_write;
  logic [2:0]            r_ctrl;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] r_pcnt;
  logic [31:0]           r_count;
  logic [31:0]           r_compare;
  logic                  r_match;
  logic                  r_irq;

  logic        w_accept;
  logic        w_legal;
  logic        w_wr;
  logic        w_tick;
  logic        w_hit;
  logic [31:0] w_rdata;
  logic        w_unused;

  // ERR1 is the only cycle that stalls the bus, so it is the only state that refuses a new address.
  assign w_accept = hsel & htrans[1] & hready & (r_state != S_ERR1);
  assign w_legal  = (hsize == 3'b010) & (haddr[1:0] == 2'b00);
  assign w_wr     = (r_state == S_DATA) & r_write;
  assign w_tick   = r_ctrl[0] & (r_pcnt == r_prescale);
  assign w_hit    = w_tick & (r_count == r_compare);
  assign w_unused = &{1'b0, haddr[31:5], htrans[0]};

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (nrst) begin
      r_state     <= S_IDLE;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_off       <= 3'd0;
      r_write     <= 1'b0;
    end else if (w_accept) begin
      r_off   <= haddr[4:2];
      r_write <= hwrite;
      if (w_legal) begin
        r_state     <= S_DATA;
        r_hreadyout <= 1'b1;
        r_hresp     <= 1'b0;
      end else begin
        r_state     <= S_ERR1;
        r_hreadyout <= 1'b0;
        r_hresp     <= 1'b1;
      end
    end else begin
      case (r_state)
        S_ERR1: begin
          r_state     <= S_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b1;
        end
        default: begin
          r_state     <= S_IDLE;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b0;
        end
      endcase
    end
  end

  // Software writes win over the tick update; a tick match wins over the W1C clear.
  always_ff @(posedge clk) begin
    if (nrst) begin
      r_ctrl     <= 3'd0;
      r_prescale <= '0;
      r_pcnt     <= '0;
      r_count    <= 32'd0;
      r_compare  <= RESET_COMPARE;
      r_match    <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr && r_off == OFF_CTRL) r_ctrl     <= hwdata[2:0];
      if (w_wr && r_off == OFF_PRE)  r_prescale <= hwdata[PRESCALE_W-1:0];
      if (w_wr && r_off == OFF_CMP)  r_compare  <= hwdata;

      if (w_wr && r_off == OFF_PRE)  r_pcnt <= '0;
      else if (r_ctrl[0])            r_pcnt <= w_tick ? '0 : r_pcnt + PCNT_ONE;

      if (w_wr && r_off == OFF_COUNT) r_count <= hwdata;
      else if (w_tick)                r_count <= (w_hit && r_ctrl[2]) ? 32'd0 : r_count + 32'd1;

      if (w_hit)                                         r_match <= 1'b1;
      else if (w_wr && r_off == OFF_STATUS && hwdata[0]) r_match <= 1'b0;

      r_irq <= r_match & r_ctrl[1];
    end
  end

  // NOTE: default assignment first so the read mux cannot infer a latch.
  always_comb begin
    w_rdata = 32'd0;
    if (r_state == S_DATA && !r_write) begin
      case (r_off)
        OFF_CTRL:   w_rdata = {29'd0, r_ctrl};
        OFF_PRE:    w_rdata = 32'(r_prescale);
        OFF_COUNT:  w_rdata = r_count;
        OFF_CMP:    w_rdata = r_compare;
        OFF_STATUS: w_rdata = {31'd0, r_match};
        default:    w_rdata = 32'd0;
      endcase
    end
  end

  assign hreadyout = r_hreadyout;
  assign hresp     = r_hresp;
  assign hrdata    = w_rdata;
  assign timer_irq = r_irq;

endmodule

// File: tb/tb_ahb_timer_satellite.sv
// Scoreboard bench for ahb_timer_satellite: directed scenarios plus randomized traffic,
// checked against a cycle-level behavioural model of the timer's register rules.
module tb_ahb_timer_satellite;

  localparam int PW = 16;

  logic        clk = 1'b0;
  logic        nrst;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic        timer_irq;

  always #5 clk = ~clk;
  assign hready = hreadyout;

  ahb_timer_satellite #(.PRESCALE_W(PW), .RESET_COMPARE(32'hFFFF_FFFF)) dut (
    .clk(clk), .nrst(nrst), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata), .timer_irq(timer_irq)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        err;
    logic [31:0] data;
    logic [4:0]  addr;
  } exp_t;
  exp_t sb_q[$];

  // Behavioural model state: register contents plus bus bookkeeping.
  logic [2:0]    m_ctrl;
  logic [PW-1:0] m_pre, m_pcnt;
  logic [31:0]   m_cnt, m_cmp;
  logic          m_match, m_irq, m_err1, m_pw;
  logic [2:0]    m_woff;

  task automatic model_reset();
    m_ctrl = 3'd0; m_pre = '0; m_pcnt = '0; m_cnt = 32'd0; m_cmp = 32'hFFFF_FFFF;
    m_match = 1'b0; m_irq = 1'b0; m_err1 = 1'b0; m_pw = 1'b0; m_woff = 3'd0;
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] off);
    case (off)
      3'd0:    return {29'd0, m_ctrl};
      3'd1:    return 32'(m_pre);
      3'd2:    return m_cnt;
      3'd3:    return m_cmp;
      3'd4:    return {31'd0, m_match};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    logic tick, hit, acc, legal, old_match;
    logic [2:0] old_ctrl;
    exp_t e;
    check("timer_irq", 32'(timer_irq), 32'(m_irq));
    if (nrst) begin
      model_reset();
      return;
    end
    old_ctrl  = m_ctrl;
    old_match = m_match;
    tick = old_ctrl[0] && (m_pcnt == m_pre);
    hit  = tick && (m_cnt == m_cmp);
    m_irq = old_match && old_ctrl[1];
    if (hit) m_match = 1'b1;
    else if (m_pw && m_woff == 3'd4 && hwdata[0]) m_match = 1'b0;
    if (m_pw && m_woff == 3'd2) m_cnt = hwdata;
    else if (tick) m_cnt = (hit && old_ctrl[2]) ? 32'd0 : m_cnt + 32'd1;
    if (m_pw && m_woff == 3'd1) m_pcnt = '0;
    else if (old_ctrl[0]) m_pcnt = tick ? '0 : PW'(m_pcnt + 1'b1);
    if (m_pw && m_woff == 3'd0) m_ctrl = hwdata[2:0];
    if (m_pw && m_woff == 3'd1) m_pre  = hwdata[PW-1:0];
    if (m_pw && m_woff == 3'd3) m_cmp  = hwdata;
    acc   = hsel && htrans[1] && !m_err1;
    legal = (hsize == 3'b010) && (haddr[1:0] == 2'b00);
    m_err1 = acc && !legal;
    m_pw   = acc && legal && hwrite;
    m_woff = haddr[4:2];
    if (acc) begin
      e.rd = !hwrite; e.err = !legal; e.data = m_read(haddr[4:2]); e.addr = haddr[4:0];
      sb_q.push_back(e);
    end
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    forever begin
      @(negedge clk); #1;
      model_step();
    end
  end

  // Monitor: follows each accepted transfer to its completing cycle and scores the response.
  initial begin
    bit   mon_dp;
    int   waits;
    logic err_wait;
    exp_t e;
    mon_dp = 0; waits = 0; err_wait = 1'b1;
    @(posedge clk);
    forever begin
      @(negedge clk); #1;
      if (nrst) begin
        sb_q.delete();
        mon_dp = 0;
      end else begin
        if (mon_dp) begin
          if (!hreadyout) begin
            waits++;
            err_wait &= hresp;
            if (waits > 4) begin
              n_tests++; n_fail++;
              $display("FAIL data_phase_timeout: waits %0d, required at most 1", waits);
              mon_dp = 0;
            end
          end else if (sb_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL scoreboard_underflow: response seen, none expected");
            mon_dp = 0;
          end else begin
            e = sb_q.pop_front();
            check($sformatf("hresp@%02h", e.addr), 32'(hresp), 32'(e.err));
            check($sformatf("waits@%02h", e.addr), 32'(waits), e.err ? 32'd1 : 32'd0);
            if (e.err) check($sformatf("err_wait_resp@%02h", e.addr), 32'(err_wait), 32'd1);
            if (e.rd && !e.err) check($sformatf("hrdata@%02h", e.addr), hrdata, e.data);
            mon_dp = 0;
          end
        end
        if (hsel && htrans[1] && hreadyout) begin
          mon_dp = 1; waits = 0; err_wait = 1'b1;
        end
      end
    end
  end

  // Driver: called on a falling edge; consecutive calls pipeline back to back.
  task automatic bus(input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [31:0] d);
    logic rdy;
    int   n;
    n = 0;
    hsel = 1'b1; haddr = a; htrans = 2'b10; hwrite = w; hsize = sz;
    while (1) begin
      rdy = hreadyout;
      @(posedge clk);
      if (rdy) break;
      n++;
      if (n > 8) begin
        n_tests++; n_fail++;
        $display("FAIL addr_accept_timeout: hready low %0d cycles", n);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00; hwdata = d;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus(a, 1'b1, 3'b010, d);
  endtask

  task automatic rd(input logic [31:0] a);
    bus(a, 1'b0, 3'b010, 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n;
    logic [31:0] a, d;
    logic [2:0]  off;
    logic        w;
    logic [2:0]  sz;
    nrst = 1'b1; hsel = 1'b0; haddr = 32'd0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'b010; hwdata = 32'd0;

    // Reset values, then COMPARE and COUNT read back.
    repeat (3) @(negedge clk);
    #1;
    check("rst_hreadyout", 32'(hreadyout), 32'd1);
    check("rst_hresp", 32'(hresp), 32'd0);
    check("rst_hrdata", hrdata, 32'd0);
    check("rst_irq", 32'(timer_irq), 32'd0);
    @(negedge clk);
    nrst = 1'b0;
    rd(32'h0C); rd(32'h08); idle(2);

    // Prescaled match with auto-reload and interrupt.
    wr(32'h04, 32'd3); wr(32'h0C, 32'd5); wr(32'h00, 32'd7);
    n = 0;
    while (!timer_irq && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    check("irq_latency", 32'(n), 32'd26);
    @(negedge clk);
    rd(32'h08); rd(32'h10);
    wr(32'h10, 32'd1);
    repeat (2) @(negedge clk);
    #1;
    check("irq_clear", 32'(timer_irq), 32'd0);
    @(negedge clk);
    wr(32'h00, 32'd0); idle(2);

    // 32-bit wrap without auto-reload; single match at COMPARE = 0.
    wr(32'h10, 32'd1); wr(32'h04, 32'd0); wr(32'h0C, 32'd0);
    wr(32'h08, 32'hFFFF_FFFE); wr(32'h00, 32'd1);
    rd(32'h08); rd(32'h08); rd(32'h08); rd(32'h08); rd(32'h10);
    wr(32'h00, 32'd0); rd(32'h08); idle(2);

    // Illegal byte write and misaligned read: two-cycle ERROR, no state change.
    bus(32'h08, 1'b1, 3'b000, 32'h1234_5678);
    #1;
    check("err1_hreadyout", 32'(hreadyout), 32'd0);
    check("err1_hresp", 32'(hresp), 32'd1);
    @(negedge clk);
    rd(32'h08);
    bus(32'h09, 1'b0, 3'b010, 32'd0);
    rd(32'h08); idle(3);

    // Back-to-back write then read of COMPARE.
    wr(32'h0C, 32'hA5A5_0F0F); rd(32'h0C); idle(2);

    // COUNT write vs tick, and MATCH set vs W1C in the same cycle.
    wr(32'h0C, 32'h0000_1002); wr(32'h10, 32'd1); wr(32'h04, 32'd0); wr(32'h00, 32'd3);
    wr(32'h08, 32'h0000_1000); rd(32'h08); rd(32'h04); wr(32'h10, 32'd1); rd(32'h10);
    idle(3);

    // Reset asserted during the first ERROR cycle.
    bus(32'h08, 1'b1, 3'b001, 32'd5);
    nrst = 1'b1;
    @(negedge clk); #1;
    check("rst_mid_hreadyout", 32'(hreadyout), 32'd1);
    check("rst_mid_hresp", 32'(hresp), 32'd0);
    check("rst_mid_hrdata", hrdata, 32'd0);
    check("rst_mid_irq", 32'(timer_irq), 32'd0);
    @(negedge clk);
    nrst = 1'b0;
    rd(32'h00); rd(32'h0C); idle(2);

    // Randomized traffic with small prescales and COUNT values near COMPARE.
    repeat (300) begin
      off = 3'($urandom_range(0, 7));
      w   = 1'($urandom_range(0, 1));
      sz  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 1)) : 3'b010;
      a   = ($urandom() & 32'hFFFF_FFE0) | {27'd0, off, 2'b00};
      if ($urandom_range(0, 11) == 0) a[1:0] = 2'($urandom_range(1, 3));
      d = $urandom();
      if (off == 3'd1) d = 32'($urandom_range(0, 3));
      if (off == 3'd2 && $urandom_range(0, 1) == 1) d = m_cmp - 32'($urandom_range(0, 8));
      if (off == 3'd3 && $urandom_range(0, 1) == 1) d = m_cnt + 32'($urandom_range(0, 8));
      bus(a, w, sz, d);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(4);
    check("scoreboard_drain", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
